dsm_sample_feeder: RTL and testbench

Rate-adapting input stage that sits directly upstream of the delta-sigma DAC core. It accepts PCM words from a producer over a valid/ready handshake and buffers them in a small FIFO. It generates the oversampling strobe every OSR clocks and presents one word per strobe on a held-stable data bus, driving the DAC core's `i_sample` and `i_data`. Buffer underruns are detected and flagged.

---
 rtl/dsm_pkg.sv | 12 +
 rtl/dsm_sample_feeder_if.sv | 35 +++
 rtl/dsm_sync_fifo.sv | 62 ++++++
 rtl/dsm_sample_feeder.sv | 92 +++++++++
 tb/tb_dsm_sample_feeder.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/dsm_pkg.sv
// Shared constants for the delta-sigma DAC path: default word width, default
// oversampling ratio and the midscale code used when no sample is available.
package dsm_pkg;

  localparam int DSM_DEFAULT_DATA_WIDTH = 4;
  localparam int DSM_DEFAULT_OSR        = 16;

  function automatic int dsm_midscale(input int data_width);
    return 1 << (data_width - 1);
  endfunction

endpackage

// File: rtl/dsm_sample_feeder_if.sv
// Producer-side handshake and DAC-side sample bus of the sample feeder.
// The feeder uses the slave modport; the producer/DAC side uses master.
interface dsm_sample_feeder_if #(
  parameter int DATA_WIDTH = 4
);

  // A word transfers on a rising edge where i_valid and o_ready are both high;
  // the producer holds i_valid/i_data stable until that edge, and o_ready does
  // not depend on i_valid.
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_ready;
  logic                  o_sample;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_underrun;

  modport master (
    output i_valid,
    output i_data,
    input  o_ready,
    input  o_sample,
    input  o_data,
    input  o_underrun
  );

  modport slave (
    input  i_valid,
    input  i_data,
    output o_ready,
    output o_sample,
    output o_data,
    output o_underrun
  );

endinterface

// File: rtl/dsm_sync_fifo.sv
// Single-clock FIFO with occupancy count; push is ignored when full and pop is
// ignored when empty. FIFO_DEPTH must be a power of two so pointers wrap freely.
module dsm_sync_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  logic                               pop,
  input  logic [DATA_WIDTH-1:0]              wdata,
  output logic [DATA_WIDTH-1:0]              rdata,
  output logic                               full,
  output logic                               empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dsm_sample_feeder.sv
// Rate adapter in front of the delta-sigma DAC core: buffers producer words and
// emits one per OSR clocks. Optional DSM_FEEDER_MIDSCALE_ON_UNDERRUN_EN loads midscale on underrun.
module dsm_sample_feeder
  import dsm_pkg::*;
#(
  parameter int DATA_WIDTH = DSM_DEFAULT_DATA_WIDTH,
  parameter int OSR        = DSM_DEFAULT_OSR,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  dsm_sample_feeder_if.slave  bus
);

  localparam int DIV_W = $clog2(OSR);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OSR - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
`ifdef DSM_FEEDER_MIDSCALE_ON_UNDERRUN_EN
  localparam logic [DATA_WIDTH-1:0] MIDSCALE = DATA_WIDTH'(dsm_midscale(DATA_WIDTH));
`endif

  logic [DIV_W-1:0]      div_cnt;
  logic                  tick;
  logic                  ready;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  sample_q;
  logic                  underrun_q;
  logic [DATA_WIDTH-1:0] data_q;

  assign tick  = (div_cnt == DIV_LAST);
  assign ready = (fifo_count != CNT_FULL);
  assign push  = bus.i_valid && ready && !fifo_full;
  // The tick pops only what was stored before this edge; no bypass of a same-edge push.
  assign pop   = tick && !fifo_empty;

  dsm_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus.i_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_ONE;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sample_q   <= 1'b0;
      underrun_q <= 1'b0;
      data_q     <= '0;
    end else begin
      sample_q   <= tick;
      underrun_q <= tick && fifo_empty;
      if (pop) begin
        data_q <= fifo_rdata;
      end
`ifdef DSM_FEEDER_MIDSCALE_ON_UNDERRUN_EN
      else if (tick) begin
        data_q <= MIDSCALE;
      end
`endif
    end
  end

  assign bus.o_ready    = ready;
  assign bus.o_sample   = sample_q;
  assign bus.o_underrun = underrun_q;
  assign bus.o_data     = data_q;

endmodule

// File: tb/tb_dsm_sample_feeder.sv
// Directed bench for dsm_sample_feeder (DATA_WIDTH=4, OSR=4, FIFO_DEPTH=4): a
// queue-based model checked every cycle plus hand-computed strobe expectations.
module tb_dsm_sample_feeder;

  localparam int DW    = 4;
  localparam int OSR   = 4;
  localparam int DEPTH = 4;
`ifdef DSM_FEEDER_MIDSCALE_ON_UNDERRUN_EN
  localparam logic [DW-1:0] U20 = 4'd8;
  localparam logic [DW-1:0] U48 = 4'd8;
  localparam logic [DW-1:0] UR  = 4'd8;
`else
  localparam logic [DW-1:0] U20 = 4'd12;
  localparam logic [DW-1:0] U48 = 4'd5;
  localparam logic [DW-1:0] UR  = 4'd0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  dsm_sample_feeder_if #(.DATA_WIDTH(DW)) bus();

  dsm_sample_feeder #(
    .DATA_WIDTH (DW),
    .OSR        (OSR),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int              n_checks = 0;
  int              n_fail   = 0;
  int              cyc      = 0;
  bit              cmp_en   = 1'b0;
  logic [DW-1:0]   m_q[$];
  logic [DW-1:0]   m_data;
  logic            m_sample;
  logic            m_und;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: edges since reset release, a word queue, and the tick rule.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_q.delete();
      cyc      = 0;
      m_data   = '0;
      m_sample = 1'b0;
      m_und    = 1'b0;
    end else begin
      bit acc;
      bit tk;
      acc      = bus.i_valid && (m_q.size() < DEPTH);
      cyc++;
      tk       = (cyc % OSR) == 0;
      m_sample = tk;
      m_und    = tk && (m_q.size() == 0);
      if (tk && m_q.size() != 0) m_data = m_q.pop_front();
`ifdef DSM_FEEDER_MIDSCALE_ON_UNDERRUN_EN
      else if (tk) m_data = DW'(1 << (DW - 1));
`endif
      if (acc) m_q.push_back(bus.i_data);
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("model o_sample",   32'(bus.o_sample),   32'(m_sample));
      chk("model o_underrun", 32'(bus.o_underrun), 32'(m_und));
      chk("model o_data",     32'(bus.o_data),     32'(m_data));
      chk("model o_ready",    32'(bus.o_ready),    32'(m_q.size() < DEPTH));
    end
  end

  task automatic goto_edge(input int n);
    int k;
    k = 0;
    while (cyc < n && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("edge reached", 32'(cyc), 32'(n));
  endtask

  task automatic push_at(input int n, input logic [DW-1:0] d);
    goto_edge(n - 1);
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    goto_edge(n);
    bus.i_valid = 1'b0;
  endtask

  task automatic push_wait(input logic [DW-1:0] d, input int exp_edge, input string name);
    logic r;
    int   k;
    r = 1'b0;
    k = 0;
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    while (!r && k < 40) begin
      @(negedge clk);
      r = bus.o_ready;
      @(posedge clk);
      #1;
      k++;
    end
    bus.i_valid = 1'b0;
    chk(name, 32'(cyc), 32'(exp_edge));
  endtask

  int            t_cyc [14] = '{4, 8, 12, 16, 20, 24, 28, 32, 36, 40, 44, 48, 52, 56};
  logic [DW-1:0] t_dat [14] = '{4'd3, 4'd7, 4'd9, 4'd12, U20, 4'd1, 4'd2, 4'd4,
                                4'd10, 4'd11, 4'd5, U48, U48, 4'd6};
  bit            t_und [14] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0};

  initial begin
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    #1 rst = 1'b1;
    #1;
    chk("reset o_data",     32'(bus.o_data),     32'(0));
    chk("reset o_sample",   32'(bus.o_sample),   32'(0));
    chk("reset o_underrun", 32'(bus.o_underrun), 32'(0));
    chk("reset o_ready",    32'(bus.o_ready),    32'(1));
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    fork
      begin
        push_at(1, 4'd3);
        push_at(2, 4'd7);
        push_at(3, 4'd9);
        push_at(4, 4'd12);
        push_at(21, 4'd1);
        push_at(22, 4'd2);
        push_at(23, 4'd4);
        push_at(24, 4'd10);
        push_at(25, 4'd11);
        @(negedge clk);
        chk("ready low when full", 32'(bus.o_ready), 32'(0));
        push_wait(4'd5, 29, "full push accept edge");
        push_at(52, 4'd6);
        push_at(57, 4'd7);
        push_at(58, 4'd3);
      end
      begin
        for (int i = 0; i < 14; i++) begin
          int k;
          k = 0;
          @(negedge clk);
          while (!bus.o_sample && k < 3 * OSR) begin
            @(negedge clk);
            k++;
          end
          chk("strobe present",  32'(bus.o_sample),   32'(1));
          chk("strobe cycle",    32'(cyc),            32'(t_cyc[i]));
          chk("strobe data",     32'(bus.o_data),     32'(t_dat[i]));
          chk("strobe underrun", 32'(bus.o_underrun), 32'(t_und[i]));
        end
      end
    join

    #2 rst = 1'b1;
    #1;
    chk("midreset o_data",     32'(bus.o_data),     32'(0));
    chk("midreset o_sample",   32'(bus.o_sample),   32'(0));
    chk("midreset o_underrun", 32'(bus.o_underrun), 32'(0));
    chk("midreset o_ready",    32'(bus.o_ready),    32'(1));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    goto_edge(3);
    @(negedge clk);
    chk("no early strobe", 32'(bus.o_sample), 32'(0));
    bus.i_valid = 1'b1;
    bus.i_data  = 4'd13;
    goto_edge(4);
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("post-reset strobe",   32'(bus.o_sample),   32'(1));
    chk("post-reset underrun", 32'(bus.o_underrun), 32'(1));
    chk("post-reset data",     32'(bus.o_data),     32'(UR));
    goto_edge(8);
    @(negedge clk);
    chk("tick-push strobe",   32'(bus.o_sample),   32'(1));
    chk("tick-push underrun", 32'(bus.o_underrun), 32'(0));
    chk("tick-push data",     32'(bus.o_data),     32'(13));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
